// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the EX/WB control pipeline.
// Holds the control bundle, opcode/funct3 constants, the pc_sel, wb_sel and
// dmem_sel encodings, the memory FSM state enum and the address-region decode.
package ctrl_pkg;

   // Control bundle driven in EX and carried into WB (rd included).
   typedef struct packed {
      logic [3:0] alu_sel;
      logic       a_sel;     // 1: rs1, 0: PC
      logic       b_sel;     // 1: immediate, 0: rs2
      logic       csr_sel;   // 1: rs1 as CSR source, 0: zimm
      logic       csr_we;
      logic [2:0] load_sel;
      logic [1:0] wb_sel;
      logic       reg_we;
      logic [4:0] rd;
   } ctrl_t;

   // RV32 major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // funct3 of the shift-right pair, the only I-type op where inst[30] matters
   localparam logic [2:0] F3_SRL_SRA = 3'b101;

   // ALU selects used outside the plain {inst[30],funct3} mapping
   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_COPY_B = 4'b1111;

   // pc_sel encodings
   localparam logic [2:0] PC_RESET = 3'd0;
   localparam logic [2:0] PC_PLUS4 = 3'd2;
   localparam logic [2:0] PC_ALU   = 3'd3;
   localparam logic [2:0] PC_JAL   = 3'd4;

   // wb_sel encodings
   localparam logic [1:0] WB_NONE = 2'd0;
   localparam logic [1:0] WB_PC4  = 2'd1;
   localparam logic [1:0] WB_MEM  = 2'd2;
   localparam logic [1:0] WB_ALU  = 2'd3;

   // dmem_sel encodings
   localparam logic [1:0] DMEM_IO   = 2'd0;
   localparam logic [1:0] DMEM_DMEM = 2'd1;
   localparam logic [1:0] DMEM_BIOS = 2'd2;

   // Multi-cycle memory access tracker
   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   // Map the top address nibble onto a memory region.
   function automatic logic [1:0] region_decode(input logic [3:0] nibble);
      logic [1:0] region;
      case (nibble)
         4'h1, 4'h3: region = DMEM_DMEM;
         4'h4:       region = DMEM_BIOS;
         default:    region = DMEM_IO;
      endcase
      return region;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder for the EX stage.
// Produces the raw (ungated) control bundle plus opcode class flags.
// Optional feature: define CTRL_PIPE_CSR_EN to decode the SYSTEM/CSR opcode;
// without it that opcode is reported as unknown.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] instruction,
   output ctrl_t       ctrl,
   output logic        unknown,
   output logic        is_mem,
   output logic        is_jal,
   output logic        is_jalr
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       inst30;
   logic [4:0] rd;
   logic       unused_inst;

   assign opcode      = instruction[6:0];
   assign funct3      = instruction[14:12];
   assign inst30      = instruction[30];
   assign rd          = instruction[11:7];
   // Register-source and immediate fields are consumed elsewhere.
   assign unused_inst = ^{instruction[31], instruction[29:15]};

   // Opcode decode into the raw control bundle; unknown opcodes leave it all zero.
   always_comb begin
      ctrl    = '0;
      unknown = 1'b0;
      is_mem  = 1'b0;
      is_jal  = 1'b0;
      is_jalr = 1'b0;
      case (opcode)
         OPC_OP: begin
            ctrl.alu_sel = {inst30, funct3};
            ctrl.a_sel   = 1'b1;
            ctrl.b_sel   = 1'b0;
            ctrl.wb_sel  = WB_ALU;
            ctrl.reg_we  = 1'b1;
            ctrl.rd      = rd;
         end
         OPC_OP_IMM: begin
            // inst[30] is immediate data except for the SRLI/SRAI pair
            ctrl.alu_sel = (funct3 == F3_SRL_SRA) ? {inst30, funct3} : {1'b0, funct3};
            ctrl.a_sel   = 1'b1;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.reg_we  = 1'b1;
            ctrl.rd      = rd;
         end
         OPC_LOAD: begin
            ctrl.alu_sel  = ALU_ADD;
            ctrl.a_sel    = 1'b1;
            ctrl.b_sel    = 1'b1;
            ctrl.load_sel = funct3;
            ctrl.wb_sel   = WB_MEM;
            ctrl.reg_we   = 1'b1;
            ctrl.rd       = rd;
            is_mem        = 1'b1;
         end
         OPC_STORE: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.a_sel   = 1'b1;
            ctrl.b_sel   = 1'b1;
            is_mem       = 1'b1;
         end
         OPC_BRANCH: begin
            // ALU forms the target PC + offset; comparator decides
            ctrl.alu_sel = ALU_ADD;
            ctrl.a_sel   = 1'b0;
            ctrl.b_sel   = 1'b1;
         end
         OPC_JAL: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.a_sel   = 1'b0;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.reg_we  = 1'b1;
            ctrl.rd      = rd;
            is_jal       = 1'b1;
         end
         OPC_JALR: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.a_sel   = 1'b1;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_PC4;
            ctrl.reg_we  = 1'b1;
            ctrl.rd      = rd;
            is_jalr      = 1'b1;
         end
         OPC_LUI: begin
            ctrl.alu_sel = ALU_COPY_B;
            ctrl.a_sel   = 1'b0;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.reg_we  = 1'b1;
            ctrl.rd      = rd;
         end
         OPC_AUIPC: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.a_sel   = 1'b0;
            ctrl.b_sel   = 1'b1;
            ctrl.wb_sel  = WB_ALU;
            ctrl.reg_we  = 1'b1;
            ctrl.rd      = rd;
         end
`ifdef CTRL_PIPE_CSR_EN
         OPC_SYSTEM: begin
            // CSR writes only; no register write-back of the old value
            ctrl.csr_we  = 1'b1;
            ctrl.csr_sel = ~funct3[2];
            ctrl.a_sel   = 1'b1;
            ctrl.reg_we  = 1'b0;
            ctrl.rd      = rd;
         end
`endif
         default: begin
            unknown = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: EX/WB control for a two-stage pipeline. Wraps ctrl_decode and
// adds the multi-cycle memory FSM, stall/flush/pc_sel hazard logic, the WB
// control register and WB->EX forwarding.
// Optional feature: CTRL_PIPE_CSR_EN (passed through to ctrl_decode).
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MEM_LAT = 1     // 1..7
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_valid,
   input  logic [31:0]     instruction,
   input  logic            should_br,
   input  logic [XLEN-1:0] alu_result,
   output ctrl_t           ex_ctrl,
   output ctrl_t           wb_ctrl,
   output logic [2:0]      pc_sel,
   output logic [1:0]      dmem_sel,
   output logic            fwd_a,
   output logic            fwd_b,
   output logic            stall,
   output logic            flush,
   output logic            illegal
);

   localparam logic [2:0] LAT_LOAD    = 3'(MEM_LAT - 1);
   localparam bit         MULTI_CYCLE = (MEM_LAT > 1);

   ctrl_t      dec_ctrl;
   logic       dec_unknown;
   logic       dec_mem;
   logic       dec_jal;
   logic       dec_jalr;
   logic       mem_req;
   logic       unused_addr;

   mem_state_t state_reg;
   mem_state_t state_next;
   logic [2:0] cnt_reg;
   logic [2:0] cnt_next;

   ctrl_decode u_decode (
      .instruction (instruction),
      .ctrl        (dec_ctrl),
      .unknown     (dec_unknown),
      .is_mem      (dec_mem),
      .is_jal      (dec_jal),
      .is_jalr     (dec_jalr)
   );

   // Only the top address nibble selects the region.
   assign dmem_sel    = region_decode(alu_result[XLEN-1:XLEN-4]);
   assign unused_addr = ^alu_result[XLEN-5:0];
   assign mem_req     = inst_valid & dec_mem & (dmem_sel != DMEM_IO);

   // Memory FSM state and latency counter; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= MEM_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Memory FSM next state: IO or single-cycle accesses never leave IDLE.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         MEM_IDLE: begin
            if (mem_req && MULTI_CYCLE) begin
               state_next = MEM_BUSY;
               cnt_next   = LAT_LOAD;
            end
         end
         MEM_BUSY: begin
            cnt_next = cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) begin
               state_next = MEM_DONE;
            end
         end
         MEM_DONE: begin
            state_next = MEM_IDLE;
         end
         default: begin
            state_next = MEM_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // FSM outputs and hazard control: stall in BUSY, redirect otherwise.
   always_comb begin
      stall   = 1'b0;
      pc_sel  = PC_RESET;
      flush   = 1'b0;
      illegal = 1'b0;
      ex_ctrl = '0;
      if (rst_n) begin
         stall   = (state_reg == MEM_BUSY);
         illegal = inst_valid & dec_unknown;

         // Branch resolution is suppressed while the access is pending.
         if (stall || !inst_valid || dec_unknown) begin
            pc_sel = PC_PLUS4;
         end else if (dec_jal) begin
            pc_sel = PC_JAL;
         end else if (dec_jalr) begin
            pc_sel = PC_ALU;
         end else if (should_br) begin
            pc_sel = PC_ALU;
         end else begin
            pc_sel = PC_PLUS4;
         end

         flush = !stall && ((pc_sel == PC_ALU) || (pc_sel == PC_JAL));

         // Architectural writes only from a valid, non-stalled EX cycle.
         ex_ctrl        = dec_ctrl;
         ex_ctrl.reg_we = dec_ctrl.reg_we & inst_valid & ~stall;
         ex_ctrl.csr_we = dec_ctrl.csr_we & inst_valid & ~stall;
      end
   end

   // WB control register: one-cycle EX->WB latency, bubble on stall/invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ctrl <= '0;
      end else if (stall || !inst_valid) begin
         wb_ctrl <= '0;
      end else begin
         wb_ctrl <= ex_ctrl;
      end
   end

   // Forwarding compare for each ALU operand: index 0 = rs1/A, 1 = rs2/B.
   logic [4:0] src_rs [2];
   logic [1:0] fwd;

   assign src_rs[0] = instruction[19:15];
   assign src_rs[1] = instruction[24:20];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd[gi] = wb_ctrl.reg_we && (wb_ctrl.rd != 5'd0) && (wb_ctrl.rd == src_rs[gi]);
      end
   endgenerate

   assign fwd_a = fwd[0];
   assign fwd_b = fwd[1];

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe with MEM_LAT=3.
// Expected values are hand-derived from the instruction encodings below.
`timescale 1ns/1ps
module tb_ctrl_pipe;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_valid;
   logic [31:0] instruction;
   logic        should_br;
   logic [31:0] alu_result;
   ctrl_t       ex_ctrl;
   ctrl_t       wb_ctrl;
   logic [2:0]  pc_sel;
   logic [1:0]  dmem_sel;
   logic        fwd_a;
   logic        fwd_b;
   logic        stall;
   logic        flush;
   logic        illegal;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   // Instruction encodings
   localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_SUB   = 32'h40118233; // sub  x4,x3,x1
   localparam logic [31:0] I_ADD5  = 32'h004002B3; // add  x5,x0,x4
   localparam logic [31:0] I_SRAI  = 32'h4030D313; // srai x6,x1,3
   localparam logic [31:0] I_ADDI  = 32'h40000093; // addi x1,x0,1024 (inst[30]=1)
   localparam logic [31:0] I_BEQ   = 32'h00208063; // beq  x1,x2,0
   localparam logic [31:0] I_JAL   = 32'h000000EF; // jal  x1,0
   localparam logic [31:0] I_JALR  = 32'h00008067; // jalr x0,0(x1)
   localparam logic [31:0] I_LW    = 32'h0000A383; // lw   x7,0(x1)
   localparam logic [31:0] I_UNK   = 32'h0000007F; // undefined opcode
   localparam logic [31:0] I_CSRRW = 32'h300110F3; // csrrw x1,0x300,x2

   localparam logic [31:0] A_IO   = 32'h8000_0000;
   localparam logic [31:0] A_DMEM = 32'h1000_0000;

   ctrl_pipe #(.XLEN(32), .MEM_LAT(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inst_valid  (inst_valid),
      .instruction (instruction),
      .should_br   (should_br),
      .alu_result  (alu_result),
      .ex_ctrl     (ex_ctrl),
      .wb_ctrl     (wb_ctrl),
      .pc_sel      (pc_sel),
      .dmem_sel    (dmem_sel),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .stall       (stall),
      .flush       (flush),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply EX inputs and let combinational outputs settle.
   task automatic drive(input logic v, input logic [31:0] inst, input logic br, input logic [31:0] addr);
      inst_valid  = v;
      instruction = inst;
      should_br   = br;
      alu_result  = addr;
      #1;
   endtask

   // Advance past one rising edge, sampling 1ns after it.
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset with active-looking inputs ----
      rst_n = 1'b0;
      drive(1'b1, I_JAL, 1'b1, A_DMEM);
      repeat (2) @(posedge clk);
      #2;
      chk("rst_pc_sel",  32'(pc_sel), 32'd0);
      chk("rst_flush",   32'(flush), 32'd0);
      chk("rst_stall",   32'(stall), 32'd0);
      chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
      drive(1'b1, I_UNK, 1'b1, A_IO);
      chk("rst_illegal", 32'(illegal), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // ---- ADD x3,x1,x2 ----
      drive(1'b1, I_ADD, 1'b0, A_IO);
      chk("add_alu_sel", 32'(ex_ctrl.alu_sel), 32'h0);
      chk("add_b_sel",   32'(ex_ctrl.b_sel), 32'd0);
      chk("add_wb_sel",  32'(ex_ctrl.wb_sel), 32'd3);
      chk("add_reg_we",  32'(ex_ctrl.reg_we), 32'd1);
      chk("add_pc_sel",  32'(pc_sel), 32'd2);
      chk("add_flush",   32'(flush), 32'd0);
      chk("add_fwd_a",   32'(fwd_a), 32'd0);
      next_cycle();

      // ---- SUB x4,x3,x1: forward A from ADD ----
      drive(1'b1, I_SUB, 1'b0, A_IO);
      chk("wb_add_rd",   32'(wb_ctrl.rd), 32'd3);
      chk("wb_add_we",   32'(wb_ctrl.reg_we), 32'd1);
      chk("sub_fwd_a",   32'(fwd_a), 32'd1);
      chk("sub_fwd_b",   32'(fwd_b), 32'd0);
      chk("sub_alu_sel", 32'(ex_ctrl.alu_sel), 32'b1000);
      next_cycle();

      // ---- ADD x5,x0,x4: forward B from SUB ----
      drive(1'b1, I_ADD5, 1'b0, A_IO);
      chk("add5_fwd_a", 32'(fwd_a), 32'd0);
      chk("add5_fwd_b", 32'(fwd_b), 32'd1);
      next_cycle();

      // ---- I-type: SRAI uses inst[30], ADDI ignores it ----
      drive(1'b1, I_SRAI, 1'b0, A_IO);
      chk("srai_alu_sel", 32'(ex_ctrl.alu_sel), 32'b1101);
      chk("srai_b_sel",   32'(ex_ctrl.b_sel), 32'd1);
      drive(1'b1, I_ADDI, 1'b0, A_IO);
      chk("addi_alu_sel", 32'(ex_ctrl.alu_sel), 32'b0000);
      next_cycle();

      // ---- BEQ taken ----
      drive(1'b1, I_BEQ, 1'b1, A_IO);
      chk("beq_pc_sel", 32'(pc_sel), 32'd3);
      chk("beq_flush",  32'(flush), 32'd1);
      next_cycle();
      drive(1'b1, I_JAL, 1'b0, A_IO);
      chk("beq_wb_we",  32'(wb_ctrl.reg_we), 32'd0);

      // ---- JAL / JALR ----
      chk("jal_pc_sel", 32'(pc_sel), 32'd4);
      chk("jal_flush",  32'(flush), 32'd1);
      chk("jal_wb_sel", 32'(ex_ctrl.wb_sel), 32'd1);
      chk("jal_reg_we", 32'(ex_ctrl.reg_we), 32'd1);
      drive(1'b1, I_JALR, 1'b0, A_IO);
      chk("jalr_pc_sel", 32'(pc_sel), 32'd3);
      next_cycle();

      // ---- unknown opcode ----
      drive(1'b1, I_UNK, 1'b1, A_IO);
      chk("unk_illegal", 32'(illegal), 32'd1);
      chk("unk_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("unk_pc_sel",  32'(pc_sel), 32'd2);
      chk("unk_flush",   32'(flush), 32'd0);

      // ---- invalid instruction: no writes, bubble into WB ----
      drive(1'b0, I_ADD, 1'b0, A_IO);
      chk("inv_reg_we",  32'(ex_ctrl.reg_we), 32'd0);
      chk("inv_illegal", 32'(illegal), 32'd0);
      next_cycle();
      chk("inv_wb_zero", 32'(wb_ctrl), 32'd0);

      // ---- region decode only (invalid so no access starts) ----
      drive(1'b0, I_LW, 1'b0, 32'h3000_0000);
      chk("dsel_3", 32'(dmem_sel), 32'd1);
      drive(1'b0, I_LW, 1'b0, 32'h4000_0000);
      chk("dsel_bios", 32'(dmem_sel), 32'd2);

      // ---- LW to DMEM, MEM_LAT=3 ----
      drive(1'b1, I_LW, 1'b0, A_DMEM);
      chk("lw_dmem_sel", 32'(dmem_sel), 32'd1);
      chk("lw_c0_stall", 32'(stall), 32'd0);
      next_cycle();
      chk("lw_c1_stall", 32'(stall), 32'd1);
      drive(1'b1, I_LW, 1'b1, A_DMEM);
      chk("lw_busy_pc_sel", 32'(pc_sel), 32'd2);
      chk("lw_busy_flush",  32'(flush), 32'd0);
      chk("lw_busy_reg_we", 32'(ex_ctrl.reg_we), 32'd0);
      next_cycle();
      chk("lw_c2_stall",  32'(stall), 32'd1);
      chk("lw_c2_wb_bub", 32'(wb_ctrl), 32'd0);
      drive(1'b1, I_LW, 1'b0, A_DMEM);
      next_cycle();
      chk("lw_done_stall",  32'(stall), 32'd0);
      chk("lw_done_pc_sel", 32'(pc_sel), 32'd2);
      next_cycle();
      chk("lw_wb_sel",   32'(wb_ctrl.wb_sel), 32'd2);
      chk("lw_load_sel", 32'(wb_ctrl.load_sel), 32'b010);
      chk("lw_wb_we",    32'(wb_ctrl.reg_we), 32'd1);
      chk("lw_idle_stall", 32'(stall), 32'd0);

      // ---- LW to IO: never stalls ----
      drive(1'b1, I_LW, 1'b0, A_IO);
      chk("io_dmem_sel", 32'(dmem_sel), 32'd0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         chk($sformatf("io_stall_%0d", i), 32'(stall), 32'd0);
      end

      // ---- CSRRW ----
      drive(1'b1, I_CSRRW, 1'b0, A_IO);
`ifdef CTRL_PIPE_CSR_EN
      chk("csr_we",      32'(ex_ctrl.csr_we), 32'd1);
      chk("csr_sel",     32'(ex_ctrl.csr_sel), 32'd1);
      chk("csr_illegal", 32'(illegal), 32'd0);
      chk("csr_reg_we",  32'(ex_ctrl.reg_we), 32'd0);
`else
      chk("csr_illegal", 32'(illegal), 32'd1);
      chk("csr_we",      32'(ex_ctrl.csr_we), 32'd0);
      chk("csr_sel",     32'(ex_ctrl.csr_sel), 32'd0);
`endif
      next_cycle();

      // ---- reset pulsed during BUSY ----
      drive(1'b1, I_LW, 1'b0, A_DMEM);
      next_cycle();
      chk("mid_busy_stall", 32'(stall), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_stall",  32'(stall), 32'd0);
      chk("mid_rst_pc_sel", 32'(pc_sel), 32'd0);
      chk("mid_rst_ex",     32'(ex_ctrl), 32'd0);
      chk("mid_rst_wb",     32'(wb_ctrl), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, I_ADD, 1'b0, A_IO);
      chk("post_rst_stall",  32'(stall), 32'd0);
      chk("post_rst_pc_sel", 32'(pc_sel), 32'd2);
      chk("post_rst_reg_we", 32'(ex_ctrl.reg_we), 32'd1);
      next_cycle();
      chk("post_rst_stall2", 32'(stall), 32'd0);
      chk("post_rst_wb_rd",  32'(wb_ctrl.rd), 32'd3);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
